// File: rtl/sseg_pkg.sv
// sseg_pkg: shared types and glyph constants for the
// eight-digit seven-segment scan controller.
package sseg_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BLANK,
      S_SHOW
   } state_e;

   localparam logic [7:0] BLANK_PAT = 8'hFF;
   localparam logic [6:0] SEG_OFF   = 7'h7F;

   // Active-low {g,f,e,d,c,b,a}; element [v] is the glyph for hex v.
   localparam logic [15:0][6:0] GLYPH = {
      7'h0E, 7'h06, 7'h21, 7'h46,
      7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19,
      7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational hex nibble to active-low
// seven-segment pattern {g,f,e,d,c,b,a}.
module hex7seg
   import sseg_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   assign seg_o = GLYPH[hex_i];

endmodule

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: time-multiplexed eight-digit display driver with
// anti-ghost blanking and a frame-aligned update handshake.
module sseg_scan_ctrl
   import sseg_pkg::*;
#(
   parameter int SHOW_CYC  = 90_000,
   parameter int BLANK_CYC = 10_000
) (
   input  logic        sysclk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] digits,
   input  logic [7:0]  dp,
   input  logic        lzs,
   input  logic        upd_valid,
   output logic        upd_ready,
   output logic [7:0]  sseg,
   output logic [7:0]  AN,
   output logic        frame_start
);

   localparam int MAX_CYC =
      (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
   localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t SHOW_LAST  = cnt_t'(SHOW_CYC - 1);
   localparam cnt_t BLANK_LAST = cnt_t'(BLANK_CYC - 1);

   state_e      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   cnt_t        cnt_q, cnt_d;

   logic [7:0]  an_q, an_d;
   logic [7:0]  seg_q, seg_d;
   logic        fs_q, fs_d;

   logic [31:0] act_dig_q, pend_dig_q;
   logic [7:0]  act_dp_q, pend_dp_q;
   logic        act_lzs_q, pend_lzs_q;
   logic        pend_q;
   logic        rdy_q;

   logic        accept;
   logic        xfer;

   logic [31:0] dig_sh;
   logic [3:0]  nib;
   logic [6:0]  glyph;
   logic        supp;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      if (!en) begin
         state_d = S_IDLE;
         idx_d   = 3'd0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d = S_BLANK;
               idx_d   = 3'd0;
               cnt_d   = '0;
            end
            S_BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d = S_SHOW;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + cnt_t'(1);
               end
            end
            S_SHOW: begin
               if (cnt_q == SHOW_LAST) begin
                  state_d = S_BLANK;
                  idx_d   = idx_q + 3'd1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + cnt_t'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
               idx_d   = 3'd0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // A blank slot only sits at count zero on its first cycle.
   assign fs_d = (state_d == S_BLANK) && (idx_d == 3'd0)
              && (cnt_d == '0);

   // Digits at and above idx_d, shifted down; zero means all leading.
   assign dig_sh = act_dig_q >> {idx_d, 2'b00};
   assign nib    = dig_sh[3:0];
   assign supp   = act_lzs_q && (idx_d != 3'd0)
                && (dig_sh == 32'd0);

   hex7seg u_dec (
      .hex_i (nib),
      .seg_o (glyph)
   );

   always_comb begin
      an_d  = BLANK_PAT;
      seg_d = BLANK_PAT;
      if (state_d == S_SHOW) begin
         an_d  = ~(8'b1 << idx_d);
         seg_d = {~act_dp_q[idx_d], supp ? SEG_OFF : glyph};
      end
   end

   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         idx_q   <= 3'd0;
         cnt_q   <= '0;
         an_q    <= BLANK_PAT;
         seg_q   <= BLANK_PAT;
         fs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         fs_q    <= fs_d;
      end
   end

   // New values only go live on a frame boundary, or at once when idle.
   assign accept = upd_valid && rdy_q;
   assign xfer   = pend_q && (fs_d || (state_q == S_IDLE));

   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         pend_dig_q <= '0;
         pend_dp_q  <= '0;
         pend_lzs_q <= 1'b0;
         pend_q     <= 1'b0;
         act_dig_q  <= '0;
         act_dp_q   <= '0;
         act_lzs_q  <= 1'b0;
         rdy_q      <= 1'b1;
      end else begin
         if (accept) begin
            pend_dig_q <= digits;
            pend_dp_q  <= dp;
            pend_lzs_q <= lzs;
            pend_q     <= 1'b1;
            rdy_q      <= 1'b0;
         end
         if (xfer) begin
            act_dig_q <= pend_dig_q;
            act_dp_q  <= pend_dp_q;
            act_lzs_q <= pend_lzs_q;
            pend_q    <= 1'b0;
            rdy_q     <= 1'b1;
         end
      end
   end

   assign upd_ready   = rdy_q;
   assign sseg        = seg_q;
   assign AN          = an_q;
   assign frame_start = fs_q;

endmodule

// File: doc/sseg_scan_ctrl.md
SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

Interface
REQ-001 SHALL have parameter SHOW_CYC, default 90_000, sysclk cycles a digit's anode is driven per slot.
REQ-002 SHALL have parameter BLANK_CYC, default 10_000, sysclk cycles all anodes are off before each slot (anti-ghosting); SHOW_CYC and BLANK_CYC both >= 1.
REQ-003 sysclk  in  1  single clock, rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 en  in  1  scan enable.
REQ-006 digits  in  32  eight hex nibbles; digit i = digits[4i+3:4i], digit 0 rightmost.
REQ-007 dp  in  8  decimal point request per digit, active-high.
REQ-008 lzs  in  1  leading-zero suppression enable.
REQ-009 upd_valid  in  1  new digits/dp/lzs offered.
REQ-010 upd_ready  out  1  update can be accepted.
REQ-011 sseg  out  8  active-low segments: [0]=a ... [6]=g, [7]=dp.
REQ-012 AN  out  8  active-low anodes, AN[i] selects digit i.
REQ-013 frame_start  out  1  one-cycle pulse when the digit-0 slot begins.

Function
REQ-014 Outputs SHALL be registered; state changes appear on outputs the cycle after the causing edge.
REQ-015 FSM states IDLE, BLANK, SHOW; slot index idx 0..7.
REQ-016 IDLE: AN=8'hFF, sseg=8'hFF; en=1 -> BLANK with idx=0.
REQ-017 BLANK: AN=8'hFF, sseg=8'hFF for exactly BLANK_CYC cycles, then SHOW.
REQ-018 SHOW: AN has only bit idx low, sseg = pattern of active digit idx for exactly SHOW_CYC cycles, then BLANK with idx+1, wrapping 7 -> 0.
REQ-019 frame_start SHALL pulse on the first BLANK cycle of every idx=0 slot, including the first after leaving IDLE.
REQ-020 en=0 in any state SHALL force IDLE next cycle, idx=0, counters cleared; AN=8'hFF that cycle.
REQ-021 Update handshake: accepted on a cycle with upd_valid=1 and upd_ready=1; digits/dp/lzs captured into a pending register; upd_ready deasserts the next cycle.
REQ-022 Pending SHALL transfer to the active register at the next frame_start (same cycle), or on the cycle after acceptance when in IDLE; upd_ready reasserts the cycle after transfer.
REQ-023 A frame SHALL never show a mix of old and new active values.
REQ-024 Segment decode covers 0-F (standard hex glyphs, b and d lowercase).
REQ-025 With active lzs=1, digit i (i>=1) is blank (segments a-g =1) when digit i and all higher digits are 0; digit 0 never suppressed.
REQ-026 dp bit sseg[7] = ~dp[idx] during SHOW, independent of suppression.
REQ-027 Slot counter width = $clog2(max(SHOW_CYC,BLANK_CYC)); no wrap inside a slot.

Reset
REQ-028 rst low SHALL immediately give: state IDLE, idx 0, AN=8'hFF, sseg=8'hFF, frame_start=0, upd_ready=1, active and pending registers 0, counters 0.
REQ-029 Reset mid-slot or mid-handshake SHALL discard pending update; operation resumes per REQ-016 after rst high.

Structure
REQ-030 Shared package sseg_pkg SHALL hold the state enum, 16-entry active-low glyph constants, and the blank pattern 8'hFF.
REQ-031 Hex-to-segment decode SHALL be a combinational sub-module hex7seg (4-bit in, 7-bit active-low out).

Verification (SHOW_CYC=4, BLANK_CYC=2)
REQ-032 rst low mid-SHOW -> AN=8'hFF, sseg=8'hFF without waiting for a clock edge; upd_ready=1.
REQ-033 Load digits=32'h76543210, dp=0, lzs=0 in IDLE, en=1 -> AN cycles FE,FD,FB,...,7F, each 4 cycles separated by 2 cycles of FF; sseg 8'hC0 on digit 0, 8'hF9 on digit 1; frame_start every 48 cycles.
REQ-034 digits=32'h00000050, lzs=1 -> digit 0 sseg=8'hC0, digit 1 sseg=8'h92, digits 2-7 sseg=8'hFF while their AN bit low.
REQ-035 Offer digits=32'h11111111 during digit-3 slot -> upd_ready low until frame_start; digits 4-7 of current frame still show old value; next frame shows 8'hF9 on all digits.
REQ-036 en=0 during digit-5 SHOW -> AN=8'hFF next cycle; en=1 -> 2 blank cycles, then digit 0 with frame_start.
REQ-037 dp=8'h04, digits=0, lzs=1 -> digit 2 sseg=8'h7F (blank glyph, dp lit).
